// File: rtl/vmm_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
// Default word width and depth live here so every instantiation site agrees.
package vmm_fifo_pkg;

  localparam int VMM_FIFO_DATA_W = 16;
  localparam int VMM_FIFO_DEPTH  = 8;

  // Ceiling log2, usable in constant (parameter) expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vmm_fifo_ram.sv
// FIFO storage: one write port, one registered read port.
// The array itself is never reset; only the read register is, so the FIFO
// output comes up as zero.
module vmm_fifo_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Storage write; a same-cycle read of the same address sees the old word.
  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read data; holds its value when no read is issued.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vmm_sync_fifo.sv
// Single-clock FIFO with occupancy count, status flags and registered output.
// Pointers carry one extra wrap bit so Count = wptr - rptr covers 0..DEPTH.
// Optional macro VMM_FIFO_ERR_EN enables the sticky OVF/UDF error flags;
// without it both outputs are tied low.
module vmm_sync_fifo
  import vmm_fifo_pkg::*;
#(
  parameter int DATA_W = VMM_FIFO_DATA_W,
  parameter int DEPTH  = VMM_FIFO_DEPTH,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    WR,
  input  logic [DATA_W-1:0]       dataIn,
  input  logic                    RD,
  output logic [DATA_W-1:0]       dataOut,
  output logic                    dataValid,
  output logic                    EMPTY,
  output logic                    FULL,
  output logic                    AEMPTY,
  output logic                    AFULL,
  output logic [clog2(DEPTH):0]   Count,
  output logic                    OVF,
  output logic                    UDF
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr, rptr, count_r;
  logic [PW-1:0] wptr_nxt, rptr_nxt;
  logic          wr_acc, rd_acc;

  // Flags are pure decodes of the registered count, so they follow reset at once.
  assign EMPTY  = (count_r == '0);
  assign FULL   = (count_r == PW'(DEPTH));
  assign AEMPTY = (count_r <= PW'(AE_LVL));
  assign AFULL  = (count_r >= PW'(AF_LVL));
  assign Count  = count_r;

  // Read only when data exists (no write-through at empty); a write at full
  // is allowed only when a read frees a slot in the same cycle.
  assign rd_acc = RD & ~EMPTY;
  assign wr_acc = WR & (~FULL | rd_acc);

  // Next pointer values.
  always_comb begin
    wptr_nxt = wptr + PW'(wr_acc);
    rptr_nxt = rptr + PW'(rd_acc);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_r <= '0;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      count_r <= wptr_nxt - rptr_nxt;
    end
  end

  // dataValid marks the cycle in which the RAM read register was refreshed.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) dataValid <= 1'b0;
    else     dataValid <= rd_acc;
  end

  vmm_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (AW)
  ) u_ram (
    .Clk   (Clk),
    .Rst   (Rst),
    .we    (wr_acc),
    .waddr (wptr[AW-1:0]),
    .wdata (dataIn),
    .re    (rd_acc),
    .raddr (rptr[AW-1:0]),
    .rdata (dataOut)
  );

`ifdef VMM_FIFO_ERR_EN
  // Sticky error flags: rejected write, or read request while empty.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      OVF <= 1'b0;
      UDF <= 1'b0;
    end else begin
      if (WR && !wr_acc) OVF <= 1'b1;
      if (RD && EMPTY)   UDF <= 1'b1;
    end
  end
`else
  assign OVF = 1'b0;
  assign UDF = 1'b0;
`endif

endmodule

// File: tb/tb_vmm_sync_fifo.sv
// Self-checking bench: instance A uses defaults (8 deep), instance B is
// 16 deep with AF_LVL=12, AE_LVL=3. Each has a queue-based reference model.
module tb_vmm_sync_fifo;

`ifdef VMM_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  localparam int DA = 8;
  localparam int DB = 16, AFB = 12, AEB = 3;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  // Instance A signals
  logic        wrA = 0, rdA = 0;
  logic [15:0] dinA = '0, doutA;
  logic        dvA, emA, fuA, aeA, afA, ovA, udA;
  logic [3:0]  cntA;
  // Instance B signals
  logic        wrB = 0, rdB = 0;
  logic [15:0] dinB = '0, doutB;
  logic        dvB, emB, fuB, aeB, afB, ovB, udB;
  logic [4:0]  cntB;

  vmm_sync_fifo dut_a (
    .Clk(Clk), .Rst(Rst), .WR(wrA), .dataIn(dinA), .RD(rdA),
    .dataOut(doutA), .dataValid(dvA), .EMPTY(emA), .FULL(fuA),
    .AEMPTY(aeA), .AFULL(afA), .Count(cntA), .OVF(ovA), .UDF(udA)
  );

  vmm_sync_fifo #(.DATA_W(16), .DEPTH(DB), .AF_LVL(AFB), .AE_LVL(AEB)) dut_b (
    .Clk(Clk), .Rst(Rst), .WR(wrB), .dataIn(dinB), .RD(rdB),
    .dataOut(doutB), .dataValid(dvB), .EMPTY(emB), .FULL(fuB),
    .AEMPTY(aeB), .AFULL(afB), .Count(cntB), .OVF(ovB), .UDF(udB)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference models: a queue of stored words plus expected output register.
  logic [15:0] qA[$], qB[$];
  logic [15:0] m_doA = '0, m_doB = '0;
  bit          m_dvA = 0, m_dvB = 0, m_ovA = 0, m_udA = 0, m_ovB = 0, m_udB = 0;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      qA.delete(); m_doA = '0; m_dvA = 0; m_ovA = 0; m_udA = 0;
    end else begin
      bit emp, ful, rok, wok;
      emp = (qA.size() == 0);
      ful = (qA.size() == DA);
      rok = rdA && !emp;
      wok = wrA && (!ful || rok);
      m_dvA = rok;
      if (rok) m_doA = qA.pop_front();
      if (wok) qA.push_back(dinA);
      if (ERR && wrA && !wok) m_ovA = 1;
      if (ERR && rdA && emp)  m_udA = 1;
    end
  end

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      qB.delete(); m_doB = '0; m_dvB = 0; m_ovB = 0; m_udB = 0;
    end else begin
      bit emp, ful, rok, wok;
      emp = (qB.size() == 0);
      ful = (qB.size() == DB);
      rok = rdB && !emp;
      wok = wrB && (!ful || rok);
      m_dvB = rok;
      if (rok) m_doB = qB.pop_front();
      if (wok) qB.push_back(dinB);
      if (ERR && wrB && !wok) m_ovB = 1;
      if (ERR && rdB && emp)  m_udB = 1;
    end
  end

  // Per-cycle comparison against the models, away from the active edge.
  always @(negedge Clk) begin
    int sa, sb;
    sa = qA.size();
    sb = qB.size();
    chk("A.count",  32'(cntA), 32'(sa));
    chk("A.empty",  32'(emA),  32'(sa == 0));
    chk("A.full",   32'(fuA),  32'(sa == DA));
    chk("A.aempty", 32'(aeA),  32'(sa <= 1));
    chk("A.afull",  32'(afA),  32'(sa >= DA - 1));
    chk("A.dv",     32'(dvA),  32'(m_dvA));
    chk("A.dout",   32'(doutA), 32'(m_doA));
    chk("A.ovf",    32'(ovA),  32'(m_ovA));
    chk("A.udf",    32'(udA),  32'(m_udA));
    chk("B.count",  32'(cntB), 32'(sb));
    chk("B.empty",  32'(emB),  32'(sb == 0));
    chk("B.full",   32'(fuB),  32'(sb == DB));
    chk("B.aempty", 32'(aeB),  32'(sb <= AEB));
    chk("B.afull",  32'(afB),  32'(sb >= AFB));
    chk("B.dv",     32'(dvB),  32'(m_dvB));
    chk("B.dout",   32'(doutB), 32'(m_doB));
    chk("B.ovf",    32'(ovB),  32'(m_ovB));
    chk("B.udf",    32'(udB),  32'(m_udB));
  end

  // One clock of stimulus on instance A; returns 1 ns after the edge.
  task automatic a_cyc(input bit w, input logic [15:0] d, input bit r);
    wrA = w; dinA = d; rdA = r;
    @(posedge Clk); #1;
    wrA = 0; rdA = 0;
  endtask

  task automatic b_cyc(input bit w, input logic [15:0] d, input bit r);
    wrB = w; dinB = d; rdB = r;
    @(posedge Clk); #1;
    wrB = 0; rdB = 0;
  endtask

  task automatic do_reset();
    @(posedge Clk); #3;
    Rst = 1;
    #4;
    Rst = 0;
    @(posedge Clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    #12 Rst = 0;
    @(posedge Clk); #1;
    chk("lit.reset_empty", 32'(emA), 32'd1);
    chk("lit.reset_count", 32'(cntA), 32'd0);
    chk("lit.reset_afull", 32'(afA), 32'd0);
    chk("lit.reset_dout",  32'(doutA), 32'd0);

    // Fill then drain with defaults.
    for (int i = 1; i <= 8; i++) begin
      a_cyc(1, 16'(i), 0);
      if (i == 7) chk("lit.fill_full7", 32'(fuA), 32'd0);
    end
    chk("lit.fill_full8", 32'(fuA), 32'd1);
    chk("lit.fill_count", 32'(cntA), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      a_cyc(0, '0, 1);
      chk("lit.drain_dv",   32'(dvA), 32'd1);
      chk("lit.drain_dout", 32'(doutA), 32'(i));
    end
    a_cyc(0, '0, 0);
    chk("lit.drain_hold_dv",   32'(dvA), 32'd0);
    chk("lit.drain_hold_dout", 32'(doutA), 32'h0008);
    chk("lit.drain_empty",     32'(emA), 32'd1);

    // Wrap: one-entry backlog carried through 20 write/read pairs.
    a_cyc(1, 16'd100, 0);
    for (int i = 0; i < 20; i++) begin
      a_cyc(1, 16'(200 + i), 1);
      chk("lit.wrap_count", 32'(cntA), 32'd1);
      chk("lit.wrap_dout",  32'(doutA), (i == 0) ? 32'd100 : 32'(199 + i));
    end
    a_cyc(0, '0, 1);
    chk("lit.wrap_last", 32'(doutA), 32'd219);

    // Simultaneous at FULL, then a rejected write at FULL.
    for (int i = 0; i < 8; i++) a_cyc(1, 16'(16'h10 + i), 0);
    a_cyc(1, 16'h0099, 1);
    chk("lit.sfull_count", 32'(cntA), 32'd8);
    chk("lit.sfull_ovf",   32'(ovA), 32'd0);
    chk("lit.sfull_dout",  32'(doutA), 32'h0010);
    a_cyc(1, 16'h00AA, 0);
    chk("lit.ovf_set", 32'(ovA), 32'(ERR));
    for (int i = 0; i < 8; i++) a_cyc(0, '0, 1);
    chk("lit.sfull_last", 32'(doutA), 32'h0099);

    // Simultaneous at EMPTY after a clean reset.
    do_reset();
    chk("lit.rst_ovf", 32'(ovA), 32'd0);
    a_cyc(1, 16'h0055, 1);
    chk("lit.sempty_count", 32'(cntA), 32'd1);
    chk("lit.sempty_dv",    32'(dvA), 32'd0);
    chk("lit.sempty_udf",   32'(udA), 32'(ERR));
    a_cyc(0, '0, 1);
    chk("lit.sempty_dout",  32'(doutA), 32'h0055);

    // Reset mid-operation: asynchronous clear between edges.
    for (int i = 0; i < 5; i++) a_cyc(1, 16'(16'h0300 + i), 0);
    chk("lit.pre_rst_count", 32'(cntA), 32'd5);
    #2 Rst = 1;
    #1;
    chk("lit.async_count", 32'(cntA), 32'd0);
    chk("lit.async_empty", 32'(emA), 32'd1);
    chk("lit.async_dout",  32'(doutA), 32'd0);
    chk("lit.async_udf",   32'(udA), 32'd0);
    @(negedge Clk); #1 Rst = 0;
    @(posedge Clk); #1;
    a_cyc(1, 16'h0077, 0);
    a_cyc(0, '0, 1);
    chk("lit.post_rst_dout", 32'(doutA), 32'h0077);
    chk("lit.post_rst_empty", 32'(emA), 32'd1);

    // Thresholds on the 16-deep instance.
    for (int i = 1; i <= 13; i++) begin
      b_cyc(1, 16'(16'h0A00 + i), 0);
      chk("lit.thr_aempty", 32'(aeB), 32'(i <= 3));
      chk("lit.thr_afull",  32'(afB), 32'(i >= 12));
    end
    for (int i = 1; i <= 13; i++) begin
      b_cyc(0, '0, 1);
      chk("lit.thr_dout", 32'(doutB), 32'(16'h0A00 + i));
    end

    @(posedge Clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vmm_sync_fifo.md
VMM_SYNC_FIFO -- requirements
Module: vmm_sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the entry count; legal values are powers of two, 2 to 1024.
REQ-003 The block SHALL have parameter AF_LVL, default DEPTH-1, giving the almost-full threshold.
REQ-004 The block SHALL have parameter AE_LVL, default 1, giving the almost-empty threshold.
REQ-005 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-006 The block SHALL have port Rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port WR, input, 1 bit: write request.
REQ-008 The block SHALL have port dataIn, input, DATA_W bits: write data.
REQ-009 The block SHALL have port RD, input, 1 bit: read request.
REQ-010 The block SHALL have port dataOut, output, DATA_W bits: registered read data.
REQ-011 The block SHALL have port dataValid, output, 1 bit: dataOut carries a newly popped word this cycle.
REQ-012 The block SHALL have ports EMPTY, FULL, AEMPTY and AFULL, outputs, 1 bit each: status flags.
REQ-013 The block SHALL have port Count, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-014 The block SHALL have ports OVF and UDF, outputs, 1 bit each: sticky overflow and underflow flags.

Function
REQ-015 A write SHALL be accepted when WR=1 and (FULL=0, or a read is accepted in the same cycle); a write is never accepted otherwise.
REQ-016 A read SHALL be accepted when RD=1 and EMPTY=0; at EMPTY a simultaneous WR is accepted and the read is rejected (no bypass).
REQ-017 The word from an accepted read SHALL appear on dataOut with dataValid=1 one cycle after acceptance.
REQ-018 dataOut SHALL hold its last value when no read is accepted; dataValid=0 in those cycles.
REQ-019 Write and read pointers SHALL be clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; storage is indexed by the low clog2(DEPTH) bits.
REQ-020 Count SHALL be registered as wptr-rptr (modulo arithmetic) and change by +1, -1 or 0 per cycle.
REQ-021 Status flags SHALL be derived from Count: EMPTY (Count==0), FULL (Count==DEPTH), AEMPTY (Count<=AE_LVL), AFULL (Count>=AF_LVL).
REQ-022 Data SHALL be returned in strict write order, with no loss or duplication across pointer wrap.

Reset
REQ-023 Asserting Rst SHALL immediately clear pointers, Count, dataOut, dataValid, OVF and UDF, with EMPTY=1, AEMPTY=1, FULL=0 and AFULL=(AF_LVL==0).
REQ-024 Storage contents SHALL NOT be reset.
REQ-025 Rst asserted mid-transfer SHALL discard all entries and any in-flight read; the first accepted write after deassertion lands at address 0.

Configuration
REQ-026 With VMM_FIFO_ERR_EN defined, OVF SHALL set when WR=1 and the write is rejected, and UDF SHALL set when RD=1 and EMPTY=1; both hold until Rst.
REQ-027 Without VMM_FIFO_ERR_EN, OVF and UDF SHALL be tied to 0 and no error logic is synthesised; the ports remain present.

Structure
REQ-028 Package vmm_fifo_pkg SHALL hold the default DATA_W and DEPTH constants and the clog2 function.
REQ-029 Storage SHALL be a sub-module vmm_fifo_ram with one write port and one registered read port; pointer, count and flag logic stays in vmm_sync_fifo.

Verification
REQ-030 Scenario fill-drain: with defaults, write 0x0001..0x0008, then read 8 -> FULL=1 after the 8th write; dataOut 0x0001..0x0008 in order, each one cycle after its RD; EMPTY=1 at the end.
REQ-031 Scenario wrap: run 20 write/read pairs with a single-entry backlog -> no data error; Count stays at 1; pointers wrap past 15.
REQ-032 Scenario simultaneous at FULL: WR=RD=1 with Count=8 -> both accepted; Count stays 8; OVF stays 0.
REQ-033 Scenario simultaneous at EMPTY: WR=RD=1 -> write accepted, read rejected; Count=1; dataValid=0; UDF=1 if VMM_FIFO_ERR_EN is defined, else 0.
REQ-034 Scenario thresholds: DEPTH=16, AF_LVL=12, AE_LVL=3, write 13 words -> AEMPTY deasserts at Count=4; AFULL asserts at Count=12.
REQ-035 Scenario reset mid-operation: assert Rst with Count=5 between clock edges -> flags and Count clear without waiting for an edge; the next write/read returns the new data.
